// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage program counter: prioritised redirect selection, sequential advance,
// and an internal circular return-address stack feeding the imem request port.
module fetch_pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    INSTR_BYTES  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'('h4),
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  trap,
    input  logic                  branch_redirect,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  jump_is_call,
    input  logic [ADDR_WIDTH-1:0] link_addr,
    input  logic                  ret,
    output logic                  ras_empty,
    output logic                  ras_overflow,
    output logic                  ras_underflow,
    output logic [2:0]            pc_src
);

    localparam int OFS   = $clog2(INSTR_BYTES);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFS;
    localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_SEQ    = 3'd1,
        SRC_RET    = 3'd2,
        SRC_JUMP   = 3'd3,
        SRC_BRANCH = 3'd4,
        SRC_TRAP   = 3'd5
    } pc_src_e;

    // Architectural state
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    pc_src_e               r_src;
    logic                  r_underflow;
    logic                  r_overflow;

    // Return-address stack: r_top points at the most recent entry
    logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]      r_top;
    logic [CNT_W-1:0]      r_count;

    // Next-state selection
    logic [ADDR_WIDTH-1:0] w_next_pc;
    pc_src_e               w_next_src;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_underflow;
    logic                  w_advance;
    logic                  w_ras_empty;
    logic                  w_ras_full;
    logic [PTR_W-1:0]      w_push_ptr;
    logic [ADDR_WIDTH-1:0] w_ras_top;

    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == FULL_CNT);
    assign w_push_ptr  = r_top + PTR_W'(1);
    assign w_ras_top   = r_ras[r_top];
    assign w_advance   = r_valid & fetch_ready & ~stall;

    // Fixed priority: trap > branch > jump > ret > advance > hold.
    // Only the winning source may touch the RAS.
    always_comb begin
        w_next_pc   = r_pc;
        w_next_src  = SRC_HOLD;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (trap) begin
            w_next_pc  = TRAP_VECTOR & ALIGN_MASK;
            w_next_src = SRC_TRAP;
        end else if (branch_redirect) begin
            w_next_pc  = branch_target & ALIGN_MASK;
            w_next_src = SRC_BRANCH;
        end else if (jump) begin
            w_next_pc  = jump_target & ALIGN_MASK;
            w_next_src = SRC_JUMP;
            w_push     = jump_is_call;
        end else if (ret) begin
            if (w_ras_empty) begin
                // Return with nothing to return to is treated as a trap
                w_next_pc   = TRAP_VECTOR & ALIGN_MASK;
                w_next_src  = SRC_TRAP;
                w_underflow = 1'b1;
            end else begin
                w_next_pc  = w_ras_top & ALIGN_MASK;
                w_next_src = SRC_RET;
                w_pop      = 1'b1;
            end
        end else if (w_advance) begin
            w_next_pc  = r_pc + INCR;
            w_next_src = SRC_SEQ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR & ALIGN_MASK;
            r_valid     <= 1'b0;
            r_src       <= SRC_HOLD;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_valid     <= 1'b1;
            r_src       <= w_next_src;
            r_underflow <= w_underflow;
        end
    end

    // A push into a full stack lands on the oldest slot, which is top+1 in the ring
    always_ff @(posedge clock) begin
        if (reset) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_push) begin
            r_top <= w_push_ptr;
            if (w_ras_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_top   <= r_top - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_ras[w_push_ptr] <= link_addr;
        end
    end

    assign fetch_valid   = r_valid;
    assign fetch_addr    = r_pc;
    assign pc_src        = r_src;
    assign ras_empty     = w_ras_empty;
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: the driver pushes the hand-computed
// post-edge output tuple per cycle; the monitor pops and compares at the falling edge.
module tb_fetch_pc_sequencer;

  localparam int W = 23;  // {valid, addr[15:0], src[2:0], empty, ovf, unf}

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [15:0] fetch_addr;
  logic        trap;
  logic        branch_redirect;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic        jump_is_call;
  logic [15:0] link_addr;
  logic        ret;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;
  logic [2:0]  pc_src;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  fetch_pc_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_addr     (fetch_addr),
    .trap           (trap),
    .branch_redirect(branch_redirect),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .jump_is_call   (jump_is_call),
    .link_addr      (link_addr),
    .ret            (ret),
    .ras_empty      (ras_empty),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow),
    .pc_src         (pc_src)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard monitor
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("fetch_valid",   16'(fetch_valid),   16'(e[22]));
      check("fetch_addr",    fetch_addr,         e[21:6]);
      check("pc_src",        16'(pc_src),        16'(e[5:3]));
      check("ras_empty",     16'(ras_empty),     16'(e[2]));
      check("ras_overflow",  16'(ras_overflow),  16'(e[1]));
      check("ras_underflow", 16'(ras_underflow), 16'(e[0]));
    end
  end

  // driver tasks
  task automatic idle();
    reset = 0; stall = 0; fetch_ready = 1;
    trap = 0; branch_redirect = 0; jump = 0; jump_is_call = 0; ret = 0;
    branch_target = 16'h0; jump_target = 16'h0; link_addr = 16'h0;
  endtask

  task automatic tick(input logic ev, input logic [15:0] ea, input logic [2:0] es,
                      input logic ee, input logic eo, input logic eu);
    exp_q.push_back({ev, ea, es, ee, eo, eu});
    @(negedge clock);
    #1;
  endtask

  task automatic do_call(input logic [15:0] tgt, input logic [15:0] lnk,
                         input logic ee, input logic eo);
    idle(); jump = 1; jump_is_call = 1; jump_target = tgt; link_addr = lnk;
    tick(1, tgt & 16'hFFFE, 3, ee, eo, 0);
  endtask

  task automatic do_ret(input logic [15:0] ea, input logic [2:0] es,
                        input logic ee, input logic eo, input logic eu);
    idle(); ret = 1;
    tick(1, ea, es, ee, eo, eu);
  endtask

  initial begin
    idle();
    reset = 1;
    tick(0, 16'h0000, 0, 1, 0, 0);
    tick(0, 16'h0000, 0, 1, 0, 0);

    // valid rises first, then sequential advance
    idle();
    tick(1, 16'h0000, 0, 1, 0, 0);
    tick(1, 16'h0002, 1, 1, 0, 0);
    tick(1, 16'h0004, 1, 1, 0, 0);
    tick(1, 16'h0006, 1, 1, 0, 0);

    // jump to 0x0010, then stall / not-ready holds
    idle(); jump = 1; jump_target = 16'h0010;
    tick(1, 16'h0010, 3, 1, 0, 0);
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) tick(1, 16'h0010, 0, 1, 0, 0);
    idle(); fetch_ready = 0;
    tick(1, 16'h0010, 0, 1, 0, 0);
    idle();
    tick(1, 16'h0012, 1, 1, 0, 0);

    // priority: trap beats branch, jump-call and ret; nothing pushed or popped
    idle(); trap = 1; branch_redirect = 1; branch_target = 16'h0100;
    jump = 1; jump_target = 16'h0300; jump_is_call = 1; link_addr = 16'h0066; ret = 1;
    tick(1, 16'h0004, 5, 1, 0, 0);
    idle(); branch_redirect = 1; branch_target = 16'h0101;
    jump = 1; jump_target = 16'h0200; jump_is_call = 1; link_addr = 16'h0066; ret = 1;
    tick(1, 16'h0100, 4, 1, 0, 0);
    // redirect ignores stall and fetch_ready
    idle(); stall = 1; fetch_ready = 0; branch_redirect = 1; branch_target = 16'h0302;
    tick(1, 16'h0302, 4, 1, 0, 0);

    // call / hold / ret
    do_call(16'h0400, 16'h0022, 0, 0);
    idle(); stall = 1;
    tick(1, 16'h0400, 0, 0, 0, 0);
    do_ret(16'h0022, 2, 1, 0, 0);

    // five calls into a four-deep stack, then five returns
    do_call(16'h0A00, 16'h0010, 0, 0);
    do_call(16'h0A10, 16'h0020, 0, 0);
    do_call(16'h0A20, 16'h0030, 0, 0);
    do_call(16'h0A30, 16'h0040, 0, 0);
    do_call(16'h0A40, 16'h0050, 0, 1);
    do_ret(16'h0050, 2, 0, 1, 0);
    do_ret(16'h0040, 2, 0, 1, 0);
    do_ret(16'h0030, 2, 0, 1, 0);
    do_ret(16'h0020, 2, 1, 1, 0);
    do_ret(16'h0004, 5, 1, 1, 1);
    idle();
    tick(1, 16'h0006, 1, 1, 1, 0);

    // misaligned link address is aligned when returned to
    do_call(16'h0700, 16'h0033, 0, 1);
    do_ret(16'h0032, 2, 1, 1, 0);

    // sequential wrap
    idle(); jump = 1; jump_target = 16'hFFFE;
    tick(1, 16'hFFFE, 3, 1, 1, 0);
    idle();
    tick(1, 16'h0000, 1, 1, 1, 0);
    tick(1, 16'h0002, 1, 1, 1, 0);

    // reset wins over a jump-call and clears the sticky overflow
    idle(); reset = 1; jump = 1; jump_is_call = 1;
    jump_target = 16'h0500; link_addr = 16'h0123;
    tick(0, 16'h0000, 0, 1, 0, 0);
    idle();
    tick(1, 16'h0000, 0, 1, 0, 0);
    tick(1, 16'h0002, 1, 1, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
